circularity_unit: RTL and testbench
===================================

Name: circularity_unit

Overview:
- Parametrised successor to the single-divide circularity calculator.
- Computes the fixed-point circularity metric C = 4·π·area·SCALE / perimeter² for one blob per transaction, using a built-in sequential restoring divider.
- Adds a ready/valid input handshake, blob tag passthrough, divide-by-zero detection and output saturation.
- Sits between the blob area/perimeter accumulator and the shape classifier in the vision pipeline.

Parameters:
- HEIGHT, 320, frame height in pixels.
- WIDTH, 180, frame width in pixels.
- SCALE, 100, output scale factor; a perfect circle gives ≈SCALE.
- PI_Q8, 804, π in unsigned Q8 (π·256, truncated).
- OUT_W, 16, width of circularity_out.
- TAG_W, 4, width of the blob tag carried with each transaction.
- Derived localparams:
  - AW = $clog2(WIDTH*HEIGHT)+1
  - NUM_W = AW+19
  - DEN_W = 2*AW+8

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, synchronous active-high reset.
- area_in, input, AW, blob pixel count.
- perimeter_in, input, AW, blob edge-pixel count.
- tag_in, input, TAG_W, blob id.
- data_valid_in, input, 1, input transaction valid.
- ready_out, output, 1, unit can accept an input.
- circularity_out, output, OUT_W, result, saturated.
- tag_out, output, TAG_W, tag of the result.
- valid_out, output, 1, single-cycle result strobe.
- error_out, output, 1, perimeter was zero (qualified by valid_out).
- sat_out, output, 1, quotient clamped (qualified by valid_out).
- busy_out, output, 1, a transaction is in flight.

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous and active-high.
- Reset values: ready_out=1; all other outputs 0; FSM in IDLE.
- Reset mid-operation aborts the transaction with no valid_out.
- Handshake:
  - A transaction is accepted on a cycle with data_valid_in & ready_out.
  - ready_out = (state==IDLE); busy_out = ~ready_out.
  - data_valid_in while not ready is ignored, not queued.
- FSM IDLE → LOAD → DIV → DONE → IDLE:
  - IDLE: on accept, register area, perimeter and tag.
  - LOAD: num = area·(4·PI_Q8·SCALE), NUM_W bits, exact; den = perimeter²·256, DEN_W bits, exact.
    - If den==0, go to DONE with the error flag set.
    - Otherwise clear the remainder and go to DIV.
  - DIV: restoring division, one quotient bit per cycle, MSB first, exactly NUM_W cycles. Quotient = floor(num/den).
  - DONE: drive the outputs and pulse valid_out for exactly one cycle, then return to IDLE.
- Latency, accept edge to valid_out:
  - Normal: NUM_W+2 cycles (38 with defaults).
  - Error: 2 cycles.
- Back-to-back: a new accept is possible on the cycle after valid_out.
- No output backpressure: the consumer must capture on the valid_out pulse.
- Result fields:
  - circularity_out, tag_out, error_out and sat_out hold their value until the next DONE.
  - Every field is a registered output.
- Saturation: if quotient > 2^OUT_W−1, circularity_out = all ones and sat_out=1.
- Error: circularity_out = all ones, error_out=1, sat_out=0.
- area=0 with nonzero perimeter gives circularity_out=0 and no flags.

Optional Feature:
- Macro CIRC_THRESH_EN.
- When defined:
  - Adds input threshold_in [OUT_W], sampled at accept.
  - Adds output is_round_out, registered with the DONE outputs: 1 iff (circularity_out ≥ threshold) & ~error.
  - is_round_out resets to 0.
- When undefined, neither port exists and there is no comparator logic.

Decomposition:
- Package circ_pkg:
  - state enum {IDLE, LOAD, DIV, DONE};
  - default constants PI_Q8_DEF=804 and SCALE_DEF=100;
  - a function computing AW from WIDTH and HEIGHT.
- Sub-module seq_restoring_divider:
  - parametrised by NUM_W and DEN_W;
  - start/done handshake, quotient and remainder outputs.
  - The top level keeps the FSM, multiply, saturation and the handshake.

Test Plan:
- Square blob: area=100, perimeter=40, tag=3 → valid_out after 38 cycles; circularity_out=78, tag_out=3, error_out=0, sat_out=0.
- Circle r=10: area=314, perimeter=63 → circularity_out=99.
- Divide by zero: area=50, perimeter=0 → valid_out 2 cycles after accept; error_out=1, circularity_out=0xFFFF.
- Saturation: area=3600, perimeter=1 → sat_out=1, circularity_out=0xFFFF.
- Busy handling: during a transaction, pulse data_valid_in with area=10, perimeter=22.
  - That input is ignored.
  - Re-present it after valid_out → circularity_out=25.
  - Assert rst_in mid-DIV → no valid_out, ready_out=1 on the next cycle.
- CIRC_THRESH_EN:
  - threshold=80 with the circle → is_round_out=1.
  - threshold=80 with the square → is_round_out=0.

Source files
------------

// File: rtl/circ_pkg.sv
// Shared definitions for the circularity unit: FSM state encoding,
// default fixed-point constants and the area-width helper.
package circ_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // pi in unsigned Q8 (pi*256, truncated) and the nominal output scale
  localparam int PI_Q8_DEF = 804;
  localparam int SCALE_DEF = 100;

  // Bits needed to hold a pixel count of a whole frame, plus one headroom bit
  function automatic int calc_aw(input int width, input int height);
    return $clog2(width * height) + 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// A start pulse loads the operands; done_out is high during the cycle whose
// closing clock edge writes the final quotient bit, so quotient_out and
// remainder_out are valid from the following cycle and then hold.
// The caller must not start with a zero denominator.
module seq_restoring_divider #(
  parameter int NUM_W = 36,
  parameter int DEN_W = 42
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [NUM_W-1:0] numerator_in,
  input  logic [DEN_W-1:0] denominator_in,
  output logic             done_out,
  output logic [NUM_W-1:0] quotient_out,
  output logic [DEN_W-1:0] remainder_out
);

  localparam int CW = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;

  // Shift the next dividend bit into the partial remainder and try a subtract
  always_comb begin
    trial = {rem_q, quo_q[NUM_W-1]};
    diff  = trial - {1'b0, den_q};
  end

  // Load on start, otherwise retire one quotient bit per cycle while active
  always_comb begin
    quo_d    = quo_q;
    rem_d    = rem_q;
    den_d    = den_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start_in) begin
      quo_d    = numerator_in;
      rem_d    = '0;
      den_d    = denominator_in;
      cnt_d    = CW'(NUM_W);
      active_d = 1'b1;
    end else if (active_q) begin
      if (trial >= {1'b0, den_q}) begin
        rem_d = diff[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
      cnt_d    = cnt_q - CW'(1);
      active_d = (cnt_q != CW'(1));
    end
  end

  // Divider state registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      quo_q    <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      den_q    <= den_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_out      = active_q && (cnt_q == CW'(1));
  assign quotient_out  = quo_q;
  assign remainder_out = rem_q;

endmodule

// File: rtl/circularity_unit.sv
// Circularity metric C = 4*pi*area*SCALE / perimeter^2 for one blob per
// transaction, with ready/valid input handshake, tag passthrough,
// divide-by-zero flagging and output saturation.
// Optional macro CIRC_THRESH_EN adds threshold_in / is_round_out.
module circularity_unit
  import circ_pkg::*;
#(
  parameter int  HEIGHT = 320,
  parameter int  WIDTH  = 180,
  parameter int  SCALE  = SCALE_DEF,
  parameter int  PI_Q8  = PI_Q8_DEF,
  parameter int  OUT_W  = 16,
  parameter int  TAG_W  = 4,
  localparam int AW     = calc_aw(WIDTH, HEIGHT),
  localparam int NUM_W  = AW + 19,
  localparam int DEN_W  = 2 * AW + 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [AW-1:0]    area_in,
  input  logic [AW-1:0]    perimeter_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             data_valid_in,
`ifdef CIRC_THRESH_EN
  input  logic [OUT_W-1:0] threshold_in,
  output logic             is_round_out,
`endif
  output logic             ready_out,
  output logic [OUT_W-1:0] circularity_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             valid_out,
  output logic             error_out,
  output logic             sat_out,
  output logic             busy_out
);

  // Constant numerator multiplier 4*pi*SCALE (pi in Q8, matched by the
  // x256 applied to the denominator)
  localparam logic [NUM_W-1:0] NUM_K   = NUM_W'(4 * PI_Q8 * SCALE);
  localparam logic [NUM_W-1:0] OUT_MAX = {{(NUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  state_e           state_q, state_d;
  logic [AW-1:0]    area_q, area_d;
  logic [AW-1:0]    perim_q, perim_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             zero_den_q, zero_den_d;

  logic [OUT_W-1:0] circ_q, circ_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             sat_q, sat_d;

`ifdef CIRC_THRESH_EN
  logic [OUT_W-1:0] thresh_q, thresh_d;
  logic             is_round_q, is_round_d;
`endif

  logic [NUM_W-1:0]   num;
  logic [DEN_W-9:0]   perim_sq;
  logic [DEN_W-1:0]   den;
  logic               div_start;
  logic               div_done;
  logic [NUM_W-1:0]   div_quo;
  logic [DEN_W-1:0]   div_rem_unused;
  logic [OUT_W-1:0]   circ_next;

  // Exact fixed-point operands formed from the registered blob measurements
  always_comb begin
    num      = NUM_W'(area_q) * NUM_K;
    perim_sq = (DEN_W-8)'(perim_q) * (DEN_W-8)'(perim_q);
    den      = {perim_sq, 8'd0};
  end

  seq_restoring_divider #(
    .NUM_W(NUM_W),
    .DEN_W(DEN_W)
  ) u_div (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (div_start),
    .numerator_in  (num),
    .denominator_in(den),
    .done_out      (div_done),
    .quotient_out  (div_quo),
    .remainder_out (div_rem_unused)
  );

  // Saturated result value presented when the transaction finishes
  always_comb begin
    circ_next = '1;
    if (!zero_den_q && (div_quo <= OUT_MAX)) begin
      circ_next = div_quo[OUT_W-1:0];
    end
  end

  // Transaction FSM: accept, form operands, divide, publish the result
  always_comb begin
    state_d    = state_q;
    area_d     = area_q;
    perim_d    = perim_q;
    tag_d      = tag_q;
    zero_den_d = zero_den_q;
    circ_d     = circ_q;
    tag_out_d  = tag_out_q;
    valid_d    = 1'b0;
    error_d    = error_q;
    sat_d      = sat_q;
    div_start  = 1'b0;
`ifdef CIRC_THRESH_EN
    thresh_d   = thresh_q;
    is_round_d = is_round_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_valid_in) begin
          area_d  = area_in;
          perim_d = perimeter_in;
          tag_d   = tag_in;
`ifdef CIRC_THRESH_EN
          thresh_d = threshold_in;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (den == '0) begin
          zero_den_d = 1'b1;
          state_d    = DONE;
        end else begin
          zero_den_d = 1'b0;
          div_start  = 1'b1;
          state_d    = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d   = 1'b1;
        tag_out_d = tag_q;
        circ_d    = circ_next;
        error_d   = zero_den_q;
        sat_d     = !zero_den_q && (div_quo > OUT_MAX);
`ifdef CIRC_THRESH_EN
        is_round_d = !zero_den_q && (circ_next >= thresh_q);
`endif
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset abandons any transaction in flight
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      area_q     <= '0;
      perim_q    <= '0;
      tag_q      <= '0;
      zero_den_q <= 1'b0;
      circ_q     <= '0;
      tag_out_q  <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      sat_q      <= 1'b0;
`ifdef CIRC_THRESH_EN
      thresh_q   <= '0;
      is_round_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      area_q     <= area_d;
      perim_q    <= perim_d;
      tag_q      <= tag_d;
      zero_den_q <= zero_den_d;
      circ_q     <= circ_d;
      tag_out_q  <= tag_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      sat_q      <= sat_d;
`ifdef CIRC_THRESH_EN
      thresh_q   <= thresh_d;
      is_round_q <= is_round_d;
`endif
    end
  end

  assign ready_out       = (state_q == IDLE);
  assign busy_out        = (state_q != IDLE);
  assign circularity_out = circ_q;
  assign tag_out         = tag_out_q;
  assign valid_out       = valid_q;
  assign error_out       = error_q;
  assign sat_out         = sat_q;
`ifdef CIRC_THRESH_EN
  assign is_round_out    = is_round_q;
`endif

endmodule

// File: tb/tb_circularity_unit.sv
// Directed testbench for circularity_unit (default parameters: AW=17).
module tb_circularity_unit;

  localparam int AW    = 17;
  localparam int OUT_W = 16;
  localparam int TAG_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic [AW-1:0]    area_in = '0;
  logic [AW-1:0]    perimeter_in = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             data_valid_in = 1'b0;
  logic             ready_out;
  logic [OUT_W-1:0] circularity_out;
  logic [TAG_W-1:0] tag_out;
  logic             valid_out;
  logic             error_out;
  logic             sat_out;
  logic             busy_out;
`ifdef CIRC_THRESH_EN
  logic [OUT_W-1:0] threshold_in = '0;
  logic             is_round_out;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  circularity_unit dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .area_in        (area_in),
    .perimeter_in   (perimeter_in),
    .tag_in         (tag_in),
    .data_valid_in  (data_valid_in),
`ifdef CIRC_THRESH_EN
    .threshold_in   (threshold_in),
    .is_round_out   (is_round_out),
`endif
    .ready_out      (ready_out),
    .circularity_out(circularity_out),
    .tag_out        (tag_out),
    .valid_out      (valid_out),
    .error_out      (error_out),
    .sat_out        (sat_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Drives one transaction and waits (bounded) for its valid_out pulse.
  // Returns with time 1ns after the edge that raised valid_out.
  task automatic applyStimulus(input logic [AW-1:0] area, input logic [AW-1:0] per,
                               input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] thr,
                               output int lat, output bit got);
    int w;
    got = 1'b0;
    lat = 0;
    w   = 0;
    while (!ready_out && w < 100) begin
      @(posedge clk_in); #1;
      w++;
    end
    area_in      = area;
    perimeter_in = per;
    tag_in       = tag;
`ifdef CIRC_THRESH_EN
    threshold_in = thr;
`else
    if (thr != '0) tag_in = tag;
`endif
    data_valid_in = 1'b1;
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk_in); #1;
      lat++;
      if (valid_out) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    n_compared++;
    if (ready_out !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %0b expected 1", ready_out); end
    n_compared++;
    if (busy_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy_out); end
    n_compared++;
    if (valid_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid_out); end
    n_compared++;
    if (circularity_out !== 16'd0) begin n_mismatched++; $display("[TB] FAIL reset_circ: got %0d expected 0", circularity_out); end
    n_compared++;
    if ({tag_out, error_out, sat_out} !== 6'd0) begin n_mismatched++; $display("[TB] FAIL reset_fields: got %0h expected 0", {tag_out, error_out, sat_out}); end
`ifdef CIRC_THRESH_EN
    n_compared++;
    if (is_round_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_round: got %0b expected 0", is_round_out); end
`endif
  endtask

  task automatic test_square();
    int lat; bit got;
    applyStimulus(17'd100, 17'd40, 4'd3, 16'd80, lat, got);
    n_compared++;
    if (got !== 1'b1 || lat != 38) begin n_mismatched++; $display("[TB] FAIL square_latency: got %0d (seen %0b) expected 38", lat, got); end
    n_compared++;
    if (circularity_out !== 16'd78) begin n_mismatched++; $display("[TB] FAIL square_circ: got %0d expected 78", circularity_out); end
    n_compared++;
    if (tag_out !== 4'd3) begin n_mismatched++; $display("[TB] FAIL square_tag: got %0d expected 3", tag_out); end
    n_compared++;
    if ({error_out, sat_out} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL square_flags: got %b expected 00", {error_out, sat_out}); end
`ifdef CIRC_THRESH_EN
    n_compared++;
    if (is_round_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL square_round: got %0b expected 0", is_round_out); end
`endif
    @(posedge clk_in); #1;
    n_compared++;
    if (valid_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL square_pulse_width: got %0b expected 0", valid_out); end
    repeat (2) @(posedge clk_in);
    #1;
    n_compared++;
    if (circularity_out !== 16'd78 || tag_out !== 4'd3) begin n_mismatched++; $display("[TB] FAIL square_hold: got %0d/%0d expected 78/3", circularity_out, tag_out); end
  endtask

  task automatic test_circle();
    int lat; bit got;
    applyStimulus(17'd314, 17'd63, 4'd5, 16'd80, lat, got);
    n_compared++;
    if (got !== 1'b1 || lat != 38) begin n_mismatched++; $display("[TB] FAIL circle_latency: got %0d (seen %0b) expected 38", lat, got); end
    n_compared++;
    if (circularity_out !== 16'd99) begin n_mismatched++; $display("[TB] FAIL circle_circ: got %0d expected 99", circularity_out); end
    n_compared++;
    if (tag_out !== 4'd5) begin n_mismatched++; $display("[TB] FAIL circle_tag: got %0d expected 5", tag_out); end
`ifdef CIRC_THRESH_EN
    n_compared++;
    if (is_round_out !== 1'b1) begin n_mismatched++; $display("[TB] FAIL circle_round: got %0b expected 1", is_round_out); end
`endif
  endtask

  task automatic test_div_zero();
    int lat; bit got;
    applyStimulus(17'd50, 17'd0, 4'd7, 16'd0, lat, got);
    n_compared++;
    if (got !== 1'b1 || lat != 2) begin n_mismatched++; $display("[TB] FAIL divzero_latency: got %0d (seen %0b) expected 2", lat, got); end
    n_compared++;
    if (circularity_out !== 16'hFFFF) begin n_mismatched++; $display("[TB] FAIL divzero_circ: got %0h expected ffff", circularity_out); end
    n_compared++;
    if ({error_out, sat_out} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL divzero_flags: got %b expected 10", {error_out, sat_out}); end
    n_compared++;
    if (tag_out !== 4'd7) begin n_mismatched++; $display("[TB] FAIL divzero_tag: got %0d expected 7", tag_out); end
`ifdef CIRC_THRESH_EN
    n_compared++;
    if (is_round_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL divzero_round: got %0b expected 0", is_round_out); end
`endif
  endtask

  task automatic test_saturation();
    int lat; bit got;
    applyStimulus(17'd3600, 17'd1, 4'd9, 16'd0, lat, got);
    n_compared++;
    if (got !== 1'b1 || lat != 38) begin n_mismatched++; $display("[TB] FAIL sat_latency: got %0d (seen %0b) expected 38", lat, got); end
    n_compared++;
    if (circularity_out !== 16'hFFFF) begin n_mismatched++; $display("[TB] FAIL sat_circ: got %0h expected ffff", circularity_out); end
    n_compared++;
    if ({error_out, sat_out} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL sat_flags: got %b expected 01", {error_out, sat_out}); end
  endtask

  task automatic test_zero_area();
    int lat; bit got;
    applyStimulus(17'd0, 17'd4, 4'd2, 16'd0, lat, got);
    n_compared++;
    if (got !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zero_area_valid: got %0b expected 1", got); end
    n_compared++;
    if (circularity_out !== 16'd0) begin n_mismatched++; $display("[TB] FAIL zero_area_circ: got %0d expected 0", circularity_out); end
    n_compared++;
    if ({error_out, sat_out} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL zero_area_flags: got %b expected 00", {error_out, sat_out}); end
  endtask

  task automatic test_busy_ignore();
    int lat; bit got; int extra;
    area_in = 17'd100; perimeter_in = 17'd40; tag_in = 4'd3;
    data_valid_in = 1'b1;
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    n_compared++;
    if ({ready_out, busy_out} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL busy_status: got %b expected 01", {ready_out, busy_out}); end
    area_in = 17'd10; perimeter_in = 17'd22; tag_in = 4'd4;
    data_valid_in = 1'b1;
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    got = 1'b0; lat = 0;
    while (!got && lat < 100) begin
      @(posedge clk_in); #1;
      lat++;
      if (valid_out) got = 1'b1;
    end
    n_compared++;
    if (got !== 1'b1 || circularity_out !== 16'd78 || tag_out !== 4'd3) begin n_mismatched++; $display("[TB] FAIL busy_first_result: got %0d tag %0d (seen %0b) expected 78 tag 3", circularity_out, tag_out, got); end
    extra = 0;
    repeat (45) begin
      @(posedge clk_in); #1;
      if (valid_out) extra++;
    end
    n_compared++;
    if (extra != 0) begin n_mismatched++; $display("[TB] FAIL busy_ignored: got %0d extra results expected 0", extra); end
    applyStimulus(17'd10, 17'd22, 4'd4, 16'd0, lat, got);
    n_compared++;
    if (got !== 1'b1 || circularity_out !== 16'd25 || tag_out !== 4'd4) begin n_mismatched++; $display("[TB] FAIL busy_represent: got %0d tag %0d (seen %0b) expected 25 tag 4", circularity_out, tag_out, got); end
  endtask

  task automatic test_back_to_back();
    int lat; bit got;
    applyStimulus(17'd314, 17'd63, 4'd1, 16'd0, lat, got);
    @(posedge clk_in); #1;
    n_compared++;
    if (ready_out !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_ready: got %0b expected 1", ready_out); end
    applyStimulus(17'd10, 17'd22, 4'd6, 16'd0, lat, got);
    n_compared++;
    if (got !== 1'b1 || lat != 38) begin n_mismatched++; $display("[TB] FAIL b2b_latency: got %0d (seen %0b) expected 38", lat, got); end
    n_compared++;
    if (circularity_out !== 16'd25 || tag_out !== 4'd6) begin n_mismatched++; $display("[TB] FAIL b2b_result: got %0d tag %0d expected 25 tag 6", circularity_out, tag_out); end
  endtask

  task automatic checkOutput_reset_mid_div();
    int lat; bit got; int seen;
    area_in = 17'd314; perimeter_in = 17'd63; tag_in = 4'd8;
    data_valid_in = 1'b1;
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    n_compared++;
    if ({ready_out, busy_out} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL midrst_ready: got %b expected 10", {ready_out, busy_out}); end
    n_compared++;
    if (circularity_out !== 16'd0 || tag_out !== 4'd0) begin n_mismatched++; $display("[TB] FAIL midrst_clear: got %0d tag %0d expected 0 tag 0", circularity_out, tag_out); end
    seen = 0;
    repeat (50) begin
      @(posedge clk_in); #1;
      if (valid_out) seen++;
    end
    n_compared++;
    if (seen != 0) begin n_mismatched++; $display("[TB] FAIL midrst_no_valid: got %0d pulses expected 0", seen); end
    applyStimulus(17'd100, 17'd40, 4'd3, 16'd0, lat, got);
    n_compared++;
    if (got !== 1'b1 || lat != 38 || circularity_out !== 16'd78) begin n_mismatched++; $display("[TB] FAIL midrst_recover: got %0d lat %0d expected 78 lat 38", circularity_out, lat); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_circle();
    test_div_zero();
    test_saturation();
    test_zero_area();
    test_busy_ignore();
    test_back_to_back();
    checkOutput_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
